// File: rtl/ntt_bf_scheduler.sv
// Butterfly scheduler for one N-point NTT pass: walks stage/group/butterfly and issues index pairs.
// Optional inverse stage ordering is compiled in with `define NTT_BF_INVERSE_EN.
module ntt_bf_scheduler #(
    parameter int unsigned N     = 8,
    parameter int unsigned LOG_N = 3,
    parameter int unsigned AW    = 5,
    parameter int unsigned OW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef NTT_BF_INVERSE_EN
    input  logic             inverse,
`endif
    output logic             busy,
    output logic             done,
    output logic             bf_valid,
    input  logic             bf_ready,
    output logic [AW-1:0]    idx_a,
    output logic [AW-1:0]    idx_b,
    output logic [LOG_N-1:0] tw_exp,
    output logic [LOG_N-1:0] stage,
    input  logic             bf_done,
    output logic             err_ovf
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

    localparam logic [LOG_N-1:0] LastS = LOG_N'(LOG_N - 1);

    state_e state_q, state_d;

    logic [LOG_N-1:0] s_q, s_d;
    logic [LOG_N-1:0] g_q, g_d;
    logic [LOG_N-1:0] k_q, k_d;
    logic [OW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             inv_q;
    logic             start_inv;

    logic [AW-1:0]    t;
    logic [AW-1:0]    a_val;
    logic [LOG_N-1:0] g_last;
    logic [LOG_N-1:0] tw_fwd;
    logic             k_wrap;
    logic             last_bf;
    logic             last_stage;
    logic             hs;
    logic             cnt_full;
    logic             drained;
    logic             active;

`ifdef NTT_BF_INVERSE_EN
    // Direction is latched at start so a toggling input cannot disturb a running pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state_q == StIdle && start) begin
            inv_q <= inverse;
        end
    end
    assign start_inv = inverse;
`else
    assign inv_q     = 1'b0;
    assign start_inv = 1'b0;
`endif

    // Loop-nest arithmetic: t = N >> (s+1), a = 2*g*t + k.
    always_comb begin
        t          = AW'(N / 2) >> s_q;
        g_last     = LOG_N'((1 << s_q) - 1);
        k_wrap     = (AW'(k_q) == (t - AW'(1)));
        last_bf    = k_wrap && (g_q == g_last);
        a_val      = ((AW'(g_q) * t) << 1) + AW'(k_q);
        tw_fwd     = k_q << s_q;
        last_stage = inv_q ? (s_q == '0) : (s_q == LastS);
        cnt_full   = (cnt_q == {OW{1'b1}});
        // A write-back arriving this cycle for the last outstanding butterfly counts as drained.
        drained    = (cnt_q == '0) || ((cnt_q == OW'(1)) && bf_done);
        hs         = bf_valid && bf_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: if (hs && last_bf) state_d = StDrain;
            StDrain: if (drained) state_d = last_stage ? StFin : StIssue;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        bf_valid = 1'b0;
        unique case (state_q)
            StIssue: begin
                busy     = 1'b1;
                bf_valid = !cnt_full;
            end
            StDrain: busy = 1'b1;
            StFin:   done = 1'b1;
            default: ;
        endcase
        active  = (state_q == StIssue) || (state_q == StDrain);
        idx_a   = active ? a_val : '0;
        idx_b   = active ? (a_val + t) : '0;
        tw_exp  = active ? (inv_q ? (LOG_N'(0) - tw_fwd) : tw_fwd) : '0;
        stage   = s_q;
        err_ovf = err_q;
    end

    always_comb begin
        s_d = s_q;
        g_d = g_q;
        k_d = k_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    s_d = start_inv ? LastS : '0;
                    g_d = '0;
                    k_d = '0;
                end
            end
            StIssue: begin
                if (hs) begin
                    if (k_wrap) begin
                        k_d = '0;
                        g_d = last_bf ? '0 : (g_q + LOG_N'(1));
                    end else begin
                        k_d = k_q + LOG_N'(1);
                    end
                end
            end
            StDrain: begin
                if (drained && !last_stage) begin
                    s_d = inv_q ? (s_q - LOG_N'(1)) : (s_q + LOG_N'(1));
                end
            end
            StFin:   s_d = '0;
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (hs && !bf_done) begin
            cnt_d = cnt_q + OW'(1);
        end else if (!hs && bf_done) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q - OW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= '0;
            g_q   <= '0;
            k_q   <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            g_q   <= g_d;
            k_q   <= k_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Self-checking bench for ntt_bf_scheduler: random handshake/write-back timing against a loop-nest model.
module tb_ntt_bf_scheduler;

    localparam int unsigned N     = 8;
    localparam int unsigned LOG_N = 3;
    localparam int unsigned AW    = 5;
    localparam int unsigned OW    = 3;
    localparam int          Total = LOG_N * N / 2;
    localparam int          Half  = N / 2;

    typedef struct {
        int a;
        int b;
        int w;
        int s;
    } xact_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic             bf_valid;
    logic             bf_ready;
    logic [AW-1:0]    idx_a;
    logic [AW-1:0]    idx_b;
    logic [LOG_N-1:0] tw_exp;
    logic [LOG_N-1:0] stage;
    logic             bf_done;
    logic             err_ovf;
`ifdef NTT_BF_INVERSE_EN
    logic             inverse;
`endif

    int checks = 0;
    int fails  = 0;

    xact_t exp_q[$];
    int    due_q[$];

    ntt_bf_scheduler #(
        .N    (N),
        .LOG_N(LOG_N),
        .AW   (AW),
        .OW   (OW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef NTT_BF_INVERSE_EN
        .inverse (inverse),
`endif
        .busy    (busy),
        .done    (done),
        .bf_valid(bf_valid),
        .bf_ready(bf_ready),
        .idx_a   (idx_a),
        .idx_b   (idx_b),
        .tw_exp  (tw_exp),
        .stage   (stage),
        .bf_done (bf_done),
        .err_ovf (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference issue order straight from the loop nest.
    function automatic void build_expected(input bit inv);
        xact_t x;
        int s;
        int t;
        exp_q.delete();
        for (int si = 0; si < int'(LOG_N); si++) begin
            s = inv ? (int'(LOG_N) - 1 - si) : si;
            t = int'(N) >> (s + 1);
            for (int g = 0; g < (1 << s); g++) begin
                for (int k = 0; k < t; k++) begin
                    x.a = 2 * g * t + k;
                    x.b = x.a + t;
                    x.w = (k << s) % int'(N);
                    if (inv) x.w = (int'(N) - x.w) % int'(N);
                    x.s = s;
                    exp_q.push_back(x);
                end
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({busy, done, bf_valid, err_ovf} !== 4'b0000) begin
            fails++;
            $display("FAIL %s_ctrl: got busy/done/valid/err=%b required 0000", tag,
                     {busy, done, bf_valid, err_ovf});
        end
        checks++;
        if ({idx_a, idx_b, tw_exp, stage} !== '0) begin
            fails++;
            $display("FAIL %s_data: got a=%0d b=%0d w=%0d s=%0d required all 0", tag,
                     idx_a, idx_b, tw_exp, stage);
        end
    endtask

    task automatic run_transform(input int rdy_pct, input int lat_min, input int lat_max,
                                 input int hold0, input bit bp_mode, input bit rand_start,
                                 input bit inv, input int abort_n);
        xact_t e;
        int    n         = 0;
        int    outst     = 0;
        int    bp_seen   = 0;
        int    cyc       = 0;
        int    last_done = -100;
        int    d;
        bit    finished  = 1'b0;
        bit    aborted   = 1'b0;
        bit    prev_stall = 1'b0;
        logic [AW-1:0]    pa, pb;
        logic [LOG_N-1:0] pw, ps;

        build_expected(inv);
        due_q.delete();
        @(posedge clk);
        #1;
        start    = 1'b1;
        bf_ready = 1'b0;
        bf_done  = 1'b0;
`ifdef NTT_BF_INVERSE_EN
        inverse  = inv;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;

        while (!finished && cyc < 2000) begin
            bf_ready = ($urandom_range(99) < rdy_pct);
            if (bp_mode && n == 1 && bp_seen < 3) bf_ready = 1'b0;
            start   = rand_start && ($urandom_range(7) == 0);
            bf_done = 1'b0;
            for (int i = 0; i < due_q.size(); i++) begin
                if (due_q[i] <= cyc) begin
                    bf_done = 1'b1;
                    due_q.delete(i);
                    break;
                end
            end
            @(negedge clk);

            if (!done) begin
                checks++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL busy_high: cyc %0d got %b required 1", cyc, busy);
                end
            end
            if (prev_stall) begin
                checks++;
                if (bf_valid !== 1'b1 || idx_a !== pa || idx_b !== pb || tw_exp !== pw ||
                    stage !== ps) begin
                    fails++;
                    $display("FAIL hold_stable: got v=%b (%0d,%0d,%0d,s%0d) required v=1 (%0d,%0d,%0d,s%0d)",
                             bf_valid, idx_a, idx_b, tw_exp, stage, pa, pb, pw, ps);
                end
            end
            if (n > 0 && n < Total && (n % Half) == 0 && outst > 0) begin
                checks++;
                if (bf_valid !== 1'b0 || stage !== LOG_N'(exp_q[n-1].s)) begin
                    fails++;
                    $display("FAIL drain_gate: got v=%b s=%0d required v=0 s=%0d (outstanding %0d)",
                             bf_valid, stage, exp_q[n-1].s, outst);
                end
            end
            if (bf_valid === 1'b1 && bf_ready === 1'b1) begin
                if (n >= Total) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_issue: got handshake %0d required at most %0d", n + 1, Total);
                end else begin
                    e = exp_q[n];
                    checks++;
                    if (idx_a !== AW'(e.a) || idx_b !== AW'(e.b) || tw_exp !== LOG_N'(e.w) ||
                        stage !== LOG_N'(e.s)) begin
                        fails++;
                        $display("FAIL issue_%0d: got (%0d,%0d,%0d,s%0d) required (%0d,%0d,%0d,s%0d)",
                                 n, idx_a, idx_b, tw_exp, stage, e.a, e.b, e.w, e.s);
                    end
                    if (n > 0 && (n % Half) == 0) begin
                        checks++;
                        if (outst != 0) begin
                            fails++;
                            $display("FAIL stage_hazard: got %0d outstanding at stage start required 0",
                                     outst);
                        end
                        if (rdy_pct == 100) begin
                            checks++;
                            if (cyc != last_done + 1) begin
                                fails++;
                                $display("FAIL stage_resume: got issue cycle %0d required %0d",
                                         cyc, last_done + 1);
                            end
                        end
                    end
                    d = cyc + $urandom_range(lat_max, lat_min);
                    if (n < Half) d += hold0;
                    due_q.push_back(d);
                    n++;
                    outst++;
                end
            end
            if (bp_mode && n == 1 && bf_valid === 1'b1 && bf_ready === 1'b0) bp_seen++;
            prev_stall = (bf_valid === 1'b1) && (bf_ready === 1'b0);
            pa = idx_a;
            pb = idx_b;
            pw = tw_exp;
            ps = stage;
            if (bf_done) begin
                outst--;
                last_done = cyc;
            end
            if (done === 1'b1) begin
                checks++;
                if (n != Total || outst != 0 || due_q.size() != 0) begin
                    fails++;
                    $display("FAIL done_early: got issued %0d outstanding %0d required %0d and 0",
                             n, outst, Total);
                end
                checks++;
                if (cyc != last_done + 1 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL done_timing: got cyc %0d busy %b required cyc %0d busy 0",
                             cyc, busy, last_done + 1);
                end
                finished = 1'b1;
            end
            if (abort_n > 0 && n >= abort_n) begin
                finished = 1'b1;
                aborted  = 1'b1;
            end
            if (!finished) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;

        if (!finished) begin
            checks++;
            fails++;
            $display("FAIL timeout: got %0d handshakes and no done required done within 2000 cycles", n);
        end else if (!aborted) begin
            @(posedge clk);
            #1;
            bf_ready = 1'b0;
            bf_done  = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || bf_valid !== 1'b0) begin
                fails++;
                $display("FAIL after_done: got done/busy/valid=%b required 000",
                         {done, busy, bf_valid});
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        bf_ready = 1'b0;
        bf_done  = 1'b0;
`ifdef NTT_BF_INVERSE_EN
        inverse  = 1'b0;
`endif
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle");
    endtask

    task automatic test_forward();
        run_transform(100, 2, 2, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_transform(100, 2, 2, 0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_stage_hazard();
        run_transform(100, 1, 1, 10, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_transform(100, 1, 3, 0, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_transform($urandom_range(90, 30), 1, $urandom_range(6, 1), 0, 1'b0, 1'b1,
                          1'b0, 0);
        end
    endtask

    task automatic test_mid_reset();
        run_transform(100, 2, 2, 0, 1'b0, 1'b0, 1'b0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        bf_ready = 1'b0;
        bf_done  = 1'b0;
        due_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset_held");
        rst_n = 1'b1;
        run_transform(100, 2, 2, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_err_ovf();
        @(negedge clk);
        checks++;
        if (err_ovf !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: got %b required 0", err_ovf);
        end
        @(posedge clk);
        #1;
        bf_done = 1'b1;
        @(posedge clk);
        #1;
        bf_done = 1'b0;
        @(negedge clk);
        checks++;
        if (err_ovf !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL err_set: got err/done/busy=%b required 100", {err_ovf, done, busy});
        end
        run_transform(100, 1, 2, 0, 1'b0, 1'b0, 1'b0, 0);
        checks++;
        if (err_ovf !== 1'b1) begin
            fails++;
            $display("FAIL err_sticky: got %b required 1", err_ovf);
        end
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("err_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef NTT_BF_INVERSE_EN
    task automatic test_inverse();
        run_transform(100, 2, 2, 0, 1'b0, 1'b0, 1'b1, 0);
        run_transform(60, 1, 4, 0, 1'b0, 1'b1, 1'b1, 0);
        run_transform(100, 2, 2, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_backpressure();
        test_stage_hazard();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_err_ovf();
`ifdef NTT_BF_INVERSE_EN
        test_inverse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ntt_bf_scheduler.md
Name: ntt_bf_scheduler

Overview:
- Sequences one full N-point NTT pass over the butterfly unit.
- Walks stages, groups and butterflies, and issues index pairs (a, b=a+t) plus a twiddle exponent over a valid/ready handshake.
- Tracks outstanding butterflies. A new stage does not issue until every write-back of the previous stage has returned, which removes read-after-write hazards in the coefficient memory.
- Sits between the top-level NTT control FSM and the butterfly/twiddle-generator datapath.

Parameters:
- N, 8, transform length (power of two, 4..32)
- LOG_N, 3, log2(N); number of stages
- AW, 5, coefficient index width
- OW, 3, outstanding-butterfly counter width; must cover maximum pipeline depth + 1

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begin a transform (ignored unless IDLE)
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse when the last butterfly of the last stage has completed
- bf_valid  output  1  butterfly request valid
- bf_ready  input  1  butterfly unit accepts request
- idx_a  output  AW  first operand index
- idx_b  output  AW  second operand index (idx_a + t)
- tw_exp  output  LOG_N  twiddle exponent, k << s
- stage  output  LOG_N  current stage number s
- bf_done  input  1  one pulse per completed butterfly write-back
- err_ovf  output  1  sticky; set if bf_done arrives while outstanding count is 0

Behaviour:
- Reset values:
  - busy=0, done=0, bf_valid=0, err_ovf=0
  - idx_a=0, idx_b=0, tw_exp=0, stage=0
  - all counters=0, FSM=IDLE
- Loop nest:
  - stage s=0..LOG_N-1, t=N>>(s+1)
  - group g=0..(1<<s)-1, butterfly k=0..t-1
  - idx_a = 2*g*t + k; idx_b = idx_a + t; tw_exp = k<<s
  - All arithmetic is in AW bits; wrap never occurs for legal N.
- FSM states:
  - IDLE: start -> ISSUE; s, g, k cleared; busy=1 next cycle.
  - ISSUE: bf_valid=1, outputs held stable while bf_ready=0. On a handshake (bf_valid&bf_ready):
    - outstanding count increments
    - k advances; k wrap advances g
    - last butterfly of the stage -> DRAIN; otherwise the next pair is presented the following cycle (1 issue/cycle max)
  - DRAIN: bf_valid=0; wait until outstanding count == 0 (including a same-cycle bf_done). Then:
    - if s==LOG_N-1 -> FIN
    - else s++, g=k=0 -> ISSUE
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- Outstanding counter:
  - handshake alone: +1; bf_done alone: -1; both in the same cycle: unchanged.
  - bf_done with count 0: count stays 0, err_ovf set (cleared only by reset).
  - The count reaching 2^OW-1 stalls issue (bf_valid deasserted) until a bf_done arrives.
- start while busy: ignored, no effect.
- rst_n low mid-transform: immediate return to reset values. No done pulse. Later bf_done pulses are treated per the err_ovf rule.
- Total handshakes per transform = LOG_N*N/2 (12 for N=8).

Optional Feature:
- Macro: NTT_BF_INVERSE_EN.
- When defined:
  - adds input port inverse (1 bit), sampled on accepted start and held for the transform
  - inverse=1: stage order reversed (s runs LOG_N-1 down to 0, t = N>>(s+1)); stage output shows s; tw_exp = (N - (k<<s)) mod N
  - inverse=0: identical to the forward transform
- When undefined: port absent; forward-only behaviour.

Test Plan:
- Forward N=8, bf_ready=1, bf_done returned 2 cycles after each handshake. Required issue order (a,b,w):
  - s0: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
  - s1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
  - s2: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
  - exactly 12 handshakes; done pulses once, after the 12th bf_done
- Backpressure: bf_ready=0 for 3 cycles on the 2nd request. Required: outputs stable at (1,5,1) throughout; no duplicate or skipped pair.
- Stage hazard: hold bf_done off for 10 cycles after s0 issues. Required: bf_valid stays 0 and stage stays 0 until the 4th bf_done; s1 issues the cycle after.
- Simultaneous handshake + bf_done: count unchanged. Spurious bf_done in IDLE: err_ovf=1.
- Mid-transform: assert rst_n=0 during s1. Required: all outputs at reset values asynchronously. A subsequent start yields a full, correct 12-pair sequence.
- With NTT_BF_INVERSE_EN, inverse=1:
  - first stage t=1, pairs (0,1,0)..(6,7,0)
  - last stage s0 (t=4): (0,4,0) (1,5,7) (2,6,6) (3,7,5)
